// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch sequencer: state encodings (also the
// value driven on the mode output), BCD digit limits and the bit positions
// of each digit inside the 16-bit time_bcd bus.
package stopwatch_pkg;

    // mode output encoding; 2'd3 is illegal and recovers to RUN
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ADJ_MIN = 2'd1,
        ADJ_SEC = 2'd2
    } state_e;

    localparam int         DIGIT_W      = 4;
    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam int         MAX_TENS_DEF = 5;
    localparam logic [3:0] BCD_MAX_TENS = 4'(MAX_TENS_DEF);

    // LSB positions of each digit in time_bcd = {min_tens, min_ones, sec_tens, sec_ones}
    localparam int MIN_TENS_LSB = 12;
    localparam int MIN_ONES_LSB = 8;
    localparam int SEC_TENS_LSB = 4;
    localparam int SEC_ONES_LSB = 0;

endpackage

// File: rtl/stopwatch_seq_bcd_mod60.sv
// bcd_mod60
// Two-digit BCD counter running 00..(MAX_TENS)9, wrapping to 00.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   inc    in   advance by one on this clock edge
//   clr    in   load 00 on this clock edge (wins over inc)
//   tens   out  registered tens digit
//   ones   out  registered ones digit
//   carry  out  combinational: inc is high while the count sits at its top value
module bcd_mod60
    import stopwatch_pkg::*;
#(
    parameter int MAX_TENS = MAX_TENS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] TENS_TOP = 4'(MAX_TENS);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    // Carry is raised regardless of clr; the parent decides whether to use it.
    assign carry = inc && (tens_q == TENS_TOP) && (ones_q == BCD_NINE);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc) begin
            if (ones_q == BCD_NINE) begin
                ones_d = 4'd0;
                tens_d = (tens_q == TENS_TOP) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_seq.sv
// stopwatch_seq
// Run/pause/adjust sequencer and MM:SS time keeper for the stopwatch.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   tick_1hz  in   one-cycle count enable (RUN, not paused)
//   tick_2hz  in   one-cycle adjust/blink enable (adjust states)
//   pause_p   in   one-cycle strobe, toggles the pause flag
//   adj_p     in   one-cycle strobe, RUN -> ADJ_MIN -> ADJ_SEC -> RUN
//   clr_p     in   one-cycle strobe, loads 00:00
//   time_bcd  out  {min_tens, min_ones, sec_tens, sec_ones}
//   blank     out  per-digit blank mask, 1 = digit dark (blinks field under adjust)
//   mode      out  current state (RUN=0, ADJ_MIN=1, ADJ_SEC=2)
//   paused    out  pause flag
//   rollover  out  one-cycle pulse when counting wraps 59:59 -> 00:00
// All inputs are single-cycle strobes: each cycle sampled high is one event,
// acted on at that edge according to the state held before the edge.
module stopwatch_seq
    import stopwatch_pkg::*;
#(
    parameter int MAX_TENS = MAX_TENS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        tick_2hz,
    input  logic        pause_p,
    input  logic        adj_p,
    input  logic        clr_p,
    output logic [15:0] time_bcd,
    output logic [3:0]  blank,
    output logic [1:0]  mode,
    output logic        paused,
    output logic        rollover
);

    state_e     state_q, state_d;
    logic       paused_q, paused_d;
    logic       phase_q, phase_d;
    logic [3:0] blank_q, blank_d;
    logic       rollover_q, rollover_d;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
    logic       sec_carry, min_carry;
    logic       run_count, sec_inc, min_inc;

    // Actions are decoded from the pre-edge state, so a tick coincident with
    // adj_p or pause_p still behaves as in the state it arrived in.
    assign run_count = (state_q == RUN) && !paused_q && tick_1hz;
    assign sec_inc   = run_count || ((state_q == ADJ_SEC) && tick_2hz);
    // The seconds carry only reaches minutes while counting; in ADJ_SEC the
    // seconds field wraps on its own.
    assign min_inc   = (run_count && sec_carry) || ((state_q == ADJ_MIN) && tick_2hz);

    bcd_mod60 #(.MAX_TENS(MAX_TENS)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .clr   (clr_p),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    bcd_mod60 #(.MAX_TENS(MAX_TENS)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .clr   (clr_p),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

    always_comb begin
        state_d    = state_q;
        paused_d   = paused_q ^ pause_p;
        phase_d    = phase_q;
        blank_d    = 4'b0000;
        rollover_d = run_count && sec_carry && min_carry && !clr_p;

        case (state_q)
            RUN:     if (adj_p) state_d = ADJ_MIN;
            ADJ_MIN: if (adj_p) state_d = ADJ_SEC;
            ADJ_SEC: if (adj_p) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (((state_q == ADJ_MIN) || (state_q == ADJ_SEC)) && tick_2hz) begin
            phase_d = ~phase_q;
        end
        // Leaving (or never being in) an adjust state restarts the blink phase.
        if (state_d == RUN) begin
            phase_d = 1'b0;
        end

        // Mask is built from next-state values so blank lines up with mode.
        case (state_d)
            ADJ_MIN: blank_d = {phase_d, phase_d, 2'b00};
            ADJ_SEC: blank_d = {2'b00, phase_d, phase_d};
            default: blank_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            paused_q   <= 1'b0;
            phase_q    <= 1'b0;
            blank_q    <= 4'b0000;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            paused_q   <= paused_d;
            phase_q    <= phase_d;
            blank_q    <= blank_d;
            rollover_q <= rollover_d;
        end
    end

    always_comb begin
        time_bcd = 16'h0000;
        time_bcd[MIN_TENS_LSB +: DIGIT_W] = min_tens;
        time_bcd[MIN_ONES_LSB +: DIGIT_W] = min_ones;
        time_bcd[SEC_TENS_LSB +: DIGIT_W] = sec_tens;
        time_bcd[SEC_ONES_LSB +: DIGIT_W] = sec_ones;
    end

    assign mode     = state_q;
    assign paused   = paused_q;
    assign blank    = blank_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_seq.sv
module tb_stopwatch_seq;

    logic        clk;
    logic        rst_n;
    logic        tick_1hz, tick_2hz, pause_p, adj_p, clr_p;
    logic [15:0] time_bcd;
    logic [3:0]  blank;
    logic [1:0]  mode;
    logic        paused, rollover;

    int n_checks = 0;
    int n_errors = 0;

    // expected {time_bcd, blank, mode, paused, rollover} per clocked step
    logic [23:0] exp_q[$];

    // reference model state (plain decimal minutes/seconds)
    int m_min, m_sec, m_state, m_paused, m_phase, m_roll;

    stopwatch_seq #(.MAX_TENS(5)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .pause_p  (pause_p),
        .adj_p    (adj_p),
        .clr_p    (clr_p),
        .time_bcd (time_bcd),
        .blank    (blank),
        .mode     (mode),
        .paused   (paused),
        .rollover (rollover)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        logic [15:0] r;
        r = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        return r;
    endfunction

    function automatic logic [23:0] model_word();
        logic [3:0] b;
        logic       ph;
        ph = m_phase[0];
        b  = 4'b0000;
        if (m_state == 1) b = {ph, ph, 2'b00};
        else if (m_state == 2) b = {2'b00, ph, ph};
        return {to_bcd(m_min, m_sec), b, 2'(m_state), m_paused[0], m_roll[0]};
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_state = 0; m_paused = 0; m_phase = 0; m_roll = 0;
    endtask

    task automatic model_edge(input logic t1, input logic t2, input logic pz,
                              input logic aj, input logic cl);
        m_roll = 0;
        if (cl) begin
            m_min = 0;
            m_sec = 0;
        end else if (m_state == 0) begin
            if (t1 && m_paused == 0) begin
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    m_min++;
                    if (m_min == 60) begin
                        m_min  = 0;
                        m_roll = 1;
                    end
                end
            end
        end else if (m_state == 1) begin
            if (t2) m_min = (m_min + 1) % 60;
        end else begin
            if (t2) m_sec = (m_sec + 1) % 60;
        end
        if (m_state != 0 && t2) m_phase ^= 1;
        if (pz) m_paused ^= 1;
        if (aj) m_state = (m_state + 1) % 3;
        if (m_state == 0) m_phase = 0;
    endtask

    // ---------------- driver ----------------
    task automatic compare_out();
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("time",     32'(time_bcd), 32'(e[23:8]));
            check("blank",    32'(blank),    32'(e[7:4]));
            check("mode",     32'(mode),     32'(e[3:2]));
            check("paused",   32'(paused),   32'(e[1]));
            check("rollover", 32'(rollover), 32'(e[0]));
        end
    endtask

    task automatic step(input logic t1, input logic t2, input logic pz,
                        input logic aj, input logic cl);
        tick_1hz = t1; tick_2hz = t2; pause_p = pz; adj_p = aj; clr_p = cl;
        model_edge(t1, t2, pz, aj, cl);
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        tick_1hz = 0; tick_2hz = 0; pause_p = 0; adj_p = 0; clr_p = 0;
        compare_out();
    endtask

    // From RUN: set MM:SS through both adjust states and return to RUN.
    task automatic goto_time(input int mm, input int ss);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_min != mm; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_sec != ss; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 0;
        tick_1hz = 0; tick_2hz = 0; pause_p = 0; adj_p = 0; clr_p = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_time",     32'(time_bcd), 32'h0000);
        check("rst_blank",    32'(blank),    32'h0);
        check("rst_mode",     32'(mode),     32'h0);
        check("rst_paused",   32'(paused),   32'h0);
        check("rst_rollover", 32'(rollover), 32'h0);
        rst_n = 1;

        // 61 seconds of counting with random idle gaps
        for (int i = 0; i < 61; i++) begin
            step(1, 0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0);
        end
        check("count61_time",  32'(time_bcd), 32'h0101);
        check("count61_blank", 32'(blank),    32'h0);
        check("count61_mode",  32'(mode),     32'h0);

        // preload 59:58, then wrap
        goto_time(59, 58);
        check("preload_time", 32'(time_bcd), 32'h5958);
        check("preload_mode", 32'(mode),     32'h0);
        step(1, 0, 0, 0, 0);
        check("wrap_5959", 32'(time_bcd), 32'h5959);
        check("wrap_roll0", 32'(rollover), 32'h0);
        step(1, 0, 0, 0, 0);
        check("wrap_0000", 32'(time_bcd), 32'h0000);
        check("wrap_roll1", 32'(rollover), 32'h1);
        step(0, 0, 0, 0, 0);
        check("wrap_roll_after", 32'(rollover), 32'h0);

        // pause suppresses counting
        step(0, 0, 1, 0, 0);
        check("pause_on", 32'(paused), 32'h1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        check("paused_time", 32'(time_bcd), 32'h0000);
        step(0, 0, 1, 0, 0);
        check("pause_off", 32'(paused), 32'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("resume_time", 32'(time_bcd), 32'h0003);

        // minutes adjust with blink; tick_1hz ignored
        step(0, 0, 0, 1, 0);
        check("adjmin_mode", 32'(mode), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(logic'($urandom_range(0, 1)), 1, 0, 0, 0);
            check("adjmin_blink", 32'(blank), (i % 2 == 0) ? 32'hC : 32'h0);
        end
        check("adjmin_time", 32'(time_bcd), 32'h0403);
        step(0, 0, 0, 1, 0);
        check("adjsec_mode", 32'(mode), 32'h2);
        for (int i = 0; i < 60; i++) step(logic'($urandom_range(0, 1)), 1, 0, 0, 0);
        check("adjsec_time", 32'(time_bcd), 32'h0403);
        check("adjsec_mode2", 32'(mode), 32'h2);
        step(0, 0, 0, 1, 0);
        check("back_run", 32'(mode), 32'h0);

        // clear coincident with a counting tick
        goto_time(12, 34);
        check("pre_clr_time", 32'(time_bcd), 32'h1234);
        step(1, 0, 0, 0, 1);
        check("clr_time",   32'(time_bcd), 32'h0000);
        check("clr_roll",   32'(rollover), 32'h0);
        check("clr_mode",   32'(mode),     32'h0);
        check("clr_paused", 32'(paused),   32'h0);
        goto_time(59, 59);
        step(1, 0, 0, 0, 1);
        check("clr5959_time", 32'(time_bcd), 32'h0000);
        check("clr5959_roll", 32'(rollover), 32'h0);

        // simultaneous strobes
        step(0, 0, 1, 1, 0);
        check("pz_aj_mode",   32'(mode),   32'h1);
        check("pz_aj_paused", 32'(paused), 32'h1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        check("cycle_run", 32'(mode), 32'h0);
        step(1, 0, 0, 1, 0);
        check("tick_adj_time", 32'(time_bcd), 32'h0001);
        check("tick_adj_mode", 32'(mode),     32'h1);
        step(0, 1, 0, 1, 0);
        check("t2_adj_time", 32'(time_bcd), 32'h0101);
        step(0, 0, 0, 1, 0);

        // random mix
        for (int i = 0; i < 300; i++) begin
            step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 14) == 0),
                 logic'($urandom_range(0, 39) == 0));
        end

        // asynchronous reset at 07:21 in ADJ_SEC
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3 && m_state != 1; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_min != 7; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 60 && m_sec != 21; i++) step(0, 1, 0, 0, 0);
        check("pre_rst_time", 32'(time_bcd), 32'h0721);
        check("pre_rst_mode", 32'(mode),     32'h2);
        #1 rst_n = 0;
        #1;
        check("arst_time",     32'(time_bcd), 32'h0000);
        check("arst_blank",    32'(blank),    32'h0);
        check("arst_mode",     32'(mode),     32'h0);
        check("arst_paused",   32'(paused),   32'h0);
        check("arst_rollover", 32'(rollover), 32'h0);
        model_reset();
        #1 rst_n = 1;
        step(1, 0, 0, 0, 0);
        check("post_rst_time", 32'(time_bcd), 32'h0001);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
